// File: rtl/wb_timer_mc.sv
// wb_timer_mc: Wishbone machine timer with a 64-bit prescaled mtime and NUM_CMP
// compare channels (one-shot or auto-reload), each with a sticky W1C pending bit.
module wb_timer_mc #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_SEL_WIDTH  = 4,
  parameter int NUM_CMP       = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
  input  logic                     wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_cyc_i,
  output logic                     wb_ack_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic [NUM_CMP-1:0]       timer_irq_o,
  output logic                     timer_irq_any_o,
  output logic                     timer_mtimecmp_accessed_o
);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  logic [5:0]         a;
  logic [3:0]         ch;
  logic [1:0]         ch_reg;
  logic               ch_valid, accept, wr, tick;
  logic               unused_addr;
  logic               ack_q, ack_d, irq_any_q, irq_any_d, acc_q, acc_d;
  logic [31:0]        rdata_q, rdata_d, rd;
  logic [63:0]        mtime_q, mtime_d, presc_q, presc_d, cnt_q, cnt_d;
  logic [NUM_CMP-1:0] en_q, en_d, pend_q, pend_d, mode_q, mode_d, irq_q, irq_d, hit;
  logic [63:0]        cmp_q [NUM_CMP];
  logic [63:0]        cmp_d [NUM_CMP];
  logic [63:0]        period_q [NUM_CMP];
  logic [63:0]        period_d [NUM_CMP];

  assign a           = wb_addr_i[7:2];
  assign ch          = a[5:2] - 4'd2;
  assign ch_reg      = a[1:0];
  assign ch_valid    = (a[5:3] != 3'd0) && (ch < 4'(NUM_CMP));
  assign accept      = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr          = accept & wb_we_i;
  assign unused_addr = ^{wb_addr_i[WB_ADDR_WIDTH-1:8], wb_addr_i[1:0]};

  always_comb begin
    mtime_d = mtime_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    mode_d  = mode_q;
    hit     = '0;
    for (int n = 0; n < NUM_CMP; n++) begin
      cmp_d[n]    = cmp_q[n];
      period_d[n] = period_q[n];
      hit[n]      = (mtime_q >= cmp_q[n]);
    end

    tick = (presc_q != 64'd0) && (cnt_q >= presc_q);
    if (presc_q != 64'd0) cnt_d = tick ? 64'd1 : cnt_q + 64'd1;
    if (tick) mtime_d = mtime_q + 64'd1;

    for (int n = 0; n < NUM_CMP; n++) begin
      if (hit[n] && mode_q[n] && (period_q[n] != 64'd0)) cmp_d[n] = cmp_q[n] + period_q[n];
    end

    // hardware set is applied after the W1C so a same-cycle hit wins
    pend_d = pend_q;
    if (wr && (a == 6'd5) && wb_sel_i[0]) pend_d = pend_q & ~wb_data_i[NUM_CMP-1:0];
    pend_d = pend_d | hit;

    if (wr) begin
      case (a)
        6'd0: mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wb_data_i, wb_sel_i)};
        6'd1: mtime_d = {merge_bytes(mtime_q[63:32], wb_data_i, wb_sel_i), mtime_q[31:0]};
        6'd2: presc_d = {presc_q[63:32], merge_bytes(presc_q[31:0], wb_data_i, wb_sel_i)};
        6'd3: presc_d = {merge_bytes(presc_q[63:32], wb_data_i, wb_sel_i), presc_q[31:0]};
        6'd4: if (wb_sel_i[0]) en_d = wb_data_i[NUM_CMP-1:0];
        6'd6: if (wb_sel_i[0]) mode_d = wb_data_i[NUM_CMP-1:0];
        default: ;
      endcase
    end

    // a software CMP write overrides the reload; the other half keeps its old value
    if (wr && ch_valid) begin
      for (int n = 0; n < NUM_CMP; n++) begin
        if (ch == 4'(n)) begin
          case (ch_reg)
            2'd0: cmp_d[n] = {cmp_q[n][63:32], merge_bytes(cmp_q[n][31:0], wb_data_i, wb_sel_i)};
            2'd1: cmp_d[n] = {merge_bytes(cmp_q[n][63:32], wb_data_i, wb_sel_i), cmp_q[n][31:0]};
            2'd2: period_d[n] = {period_q[n][63:32],
                                 merge_bytes(period_q[n][31:0], wb_data_i, wb_sel_i)};
            default: period_d[n] = {merge_bytes(period_q[n][63:32], wb_data_i, wb_sel_i),
                                    period_q[n][31:0]};
          endcase
        end
      end
    end

    rd = '0;
    case (a)
      6'd0: rd = mtime_q[31:0];
      6'd1: rd = mtime_q[63:32];
      6'd2: rd = presc_q[31:0];
      6'd3: rd = presc_q[63:32];
      6'd4: rd[NUM_CMP-1:0] = en_q;
      6'd5: rd[NUM_CMP-1:0] = pend_q;
      6'd6: rd[NUM_CMP-1:0] = mode_q;
      default: begin
        if (ch_valid) begin
          for (int n = 0; n < NUM_CMP; n++) begin
            if (ch == 4'(n)) begin
              case (ch_reg)
                2'd0:    rd = cmp_q[n][31:0];
                2'd1:    rd = cmp_q[n][63:32];
                2'd2:    rd = period_q[n][31:0];
                default: rd = period_q[n][63:32];
              endcase
            end
          end
        end
      end
    endcase

    ack_d     = accept;
    rdata_d   = accept ? rd : rdata_q;
    irq_d     = pend_q & en_q;
    irq_any_d = |(pend_q & en_q);
    acc_d     = wr & ch_valid & ~ch_reg[1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      mtime_q   <= '0;
      presc_q   <= '0;
      cnt_q     <= 64'd1;
      en_q      <= '0;
      pend_q    <= '0;
      mode_q    <= '0;
      irq_q     <= '0;
      irq_any_q <= 1'b0;
      acc_q     <= 1'b0;
      for (int n = 0; n < NUM_CMP; n++) begin
        cmp_q[n]    <= '1;
        period_q[n] <= '0;
      end
    end else begin
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      mtime_q   <= mtime_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      pend_q    <= pend_d;
      mode_q    <= mode_d;
      irq_q     <= irq_d;
      irq_any_q <= irq_any_d;
      acc_q     <= acc_d;
      for (int n = 0; n < NUM_CMP; n++) begin
        cmp_q[n]    <= cmp_d[n];
        period_q[n] <= period_d[n];
      end
    end
  end

  assign wb_ack_o                  = ack_q;
  assign wb_data_o                 = rdata_q;
  assign timer_irq_o               = irq_q;
  assign timer_irq_any_o           = irq_any_q;
  assign timer_mtimecmp_accessed_o = acc_q;

endmodule
